hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage MIPS core.
- Watches the ID/EX/MEM stage fields and drives the per-stage Stall/flush inputs of the pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
- Resolves four hazard sources: data-memory wait, multi-cycle MUL/DIV occupancy, taken branches and load-use.
- Also keeps a memory-timeout error flag and a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage MIPS core: resolves dmem wait, MUL/DIV
// occupancy, taken branches and load-use into per-stage stall/flush controls.
module hazard_ctrl #(
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        EX_MemR,
    input  logic [4:0]  EX_Rdst,
    input  logic        EX_MD_start,
    input  logic        EX_BrTaken,
    input  logic        MEM_MemR,
    input  logic        MEM_MemW,
    input  logic        dmem_ready,
    output logic        PC_Stall,
    output logic        IF_ID_Stall,
    output logic        ID_EX_Stall,
    output logic        EX_MEM_Stall,
    output logic        MEM_WB_Stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        md_busy,
    output logic        bus_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic {M_RUN, M_WAIT} mstate_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [3:0] MD_LOAD   = 4'(MD_LAT - 1);

    mstate_t     state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic mem_acc, wait_last, mem_hold, md_hold, load_use;

    assign mem_acc   = MEM_MemR | MEM_MemW;
    assign wait_last = (state_q == M_WAIT) && (wait_cnt_q == WAIT_LAST);
    // On the timeout cycle the hold is dropped so the pipeline can drain.
    assign mem_hold  = mem_acc & ~dmem_ready & ~wait_last;
    assign md_hold   = (md_cnt_q != 4'd0) | EX_MD_start;
    assign load_use  = EX_MemR && (EX_Rdst != 5'd0) &&
                       ((ID_UseRs && (ID_Rs == EX_Rdst)) ||
                        (ID_UseRt && (ID_Rt == EX_Rdst)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = bus_err_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            M_RUN: begin
                if (mem_acc && !dmem_ready) begin
                    state_d    = M_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            M_WAIT: begin
                if (dmem_ready) begin
                    state_d = M_RUN;
                end else if (wait_last) begin
                    bus_err_d = 1'b1;
                    state_d   = M_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = M_RUN;
        endcase

        // The occupancy timer keeps running under a memory hold; only the
        // initial load waits for the memory stage to be free.
        if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
        else if (EX_MD_start && !mem_hold)
            md_cnt_d = MD_LOAD;

        if (PC_Stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= M_RUN;
            wait_cnt_q  <= 8'd0;
            md_cnt_q    <= 4'd0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            md_cnt_q    <= md_cnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        PC_Stall     = 1'b0;
        IF_ID_Stall  = 1'b0;
        ID_EX_Stall  = 1'b0;
        EX_MEM_Stall = 1'b0;
        MEM_WB_Stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;

        if (mem_hold) begin
            PC_Stall     = 1'b1;
            IF_ID_Stall  = 1'b1;
            ID_EX_Stall  = 1'b1;
            EX_MEM_Stall = 1'b1;
            MEM_WB_Stall = 1'b1;
        end else if (md_hold) begin
            PC_Stall     = 1'b1;
            IF_ID_Stall  = 1'b1;
            ID_EX_Stall  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (EX_BrTaken) begin
            // The squashed ID instruction makes any load-use moot.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            PC_Stall    = 1'b1;
            IF_ID_Stall = 1'b1;
            ID_EX_flush = 1'b1;
        end
    end

    assign md_busy   = md_hold;
    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
